spi_regbank_slave: RTL and testbench

//  SPI mode-0 slave with a parametrised register bank for the ADC front end. Each frame is
//  one 8-bit command followed by one DATA_W-bit data word. Written registers drive the

---
 rtl/spi_regbank_slave.sv | 230 +++++++++++++++++++++++
 tb/tb_spi_regbank_slave.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_regbank_slave.sv
// SPI mode-0 slave with a parametrised control register bank and a free-running cycle counter.
// Frame = 8-bit command {W, ADDR[6:0]} followed by a DATA_W-bit data word, both MSB first.
// All SPI pins are asynchronous to clk and are resynchronised before use.
`timescale 1ns / 1ps

module spi_regbank_slave #(
   parameter int unsigned       DATA_W   = 32,
   parameter int unsigned       NREG     = 4,
   parameter logic [DATA_W-1:0] REG_INIT = '0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   sck,
   input  logic                   ssel,
   input  logic                   mosi,
   output logic                   miso,
   output logic [NREG*DATA_W-1:0] regs_out,
   output logic                   wr_strobe,
   output logic [6:0]             wr_addr,
   output logic [DATA_W-1:0]      count,
   output logic                   frame_err
);

   localparam int unsigned FrameLen = 8 + DATA_W;
   localparam int unsigned BitMax   = FrameLen + 1;
   localparam int unsigned CntW     = $clog2(BitMax + 1);

   localparam logic [CntW-1:0] BitCmdM1  = CntW'(7);
   localparam logic [CntW-1:0] BitCmd    = CntW'(8);
   localparam logic [CntW-1:0] BitLastM1 = CntW'(FrameLen - 1);
   localparam logic [CntW-1:0] BitLast   = CntW'(FrameLen);
   localparam logic [CntW-1:0] BitSat    = CntW'(BitMax);

   localparam logic [6:0] AddrCount  = 7'h7F;
   localparam logic [6:0] AddrErrClr = 7'h7E;

   typedef enum logic [1:0] {
      StDisarmed,
      StIdle,
      StFrame
   } state_e;

   // Synchroniser and edge-detect stages
   logic [1:0] sck_sync_q, ssel_sync_q, mosi_sync_q;
   logic       sck_prev_q, ssel_prev_q;
   logic       sck_rise, sck_fall, ssel_rise, ssel_fall, ssel_high, mosi_s;

   // Frame state
   state_e              state_q, state_d;
   logic [CntW-1:0]     bitcnt_q, bitcnt_d;
   logic [DATA_W-1:0]   shin_q, shin_d;
   logic [DATA_W-1:0]   shout_q, shout_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata;
   logic [7:0]          cmd_q, cmd_d, cmd_in;
   logic                commit_q, commit_d;
   logic                err_set;

   // Register bank and counter
   logic [NREG-1:0][DATA_W-1:0] regs_q, regs_d;
   logic [DATA_W-1:0]           count_q, count_d;
   logic                        frame_err_q, frame_err_d;
   logic                        wr_strobe_q, wr_strobe_d;
   logic [6:0]                  wr_addr_q, wr_addr_d;

   // Two-flop synchronisers plus one edge-detect flop; ssel resets low so a select that is
   // already low at reset release never looks like a frame start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_sync_q  <= '0;
         ssel_sync_q <= '0;
         mosi_sync_q <= '0;
         sck_prev_q  <= 1'b0;
         ssel_prev_q <= 1'b0;
      end else begin
         sck_sync_q  <= {sck_sync_q[0], sck};
         ssel_sync_q <= {ssel_sync_q[0], ssel};
         mosi_sync_q <= {mosi_sync_q[0], mosi};
         sck_prev_q  <= sck_sync_q[1];
         ssel_prev_q <= ssel_sync_q[1];
      end
   end

   assign sck_rise  = sck_sync_q[1] & ~sck_prev_q;
   assign sck_fall  = ~sck_sync_q[1] & sck_prev_q;
   assign ssel_rise = ssel_sync_q[1] & ~ssel_prev_q;
   assign ssel_fall = ~ssel_sync_q[1] & ssel_prev_q;
   assign ssel_high = ssel_sync_q[1];
   assign mosi_s    = mosi_sync_q[1];

   // Command byte as it stands once the current rising-edge bit is shifted in
   assign cmd_in = {shin_q[6:0], mosi_s};

   // Read-data mux, addressed by the command completing on this edge
   always_comb begin
      rdata = '0;
      if (cmd_in[6:0] == AddrCount) begin
         rdata = count_q;
      end else if (cmd_in[6:0] == AddrErrClr) begin
         rdata[0] = frame_err_q;
      end else begin
         for (int unsigned k = 0; k < NREG; k++) begin
            if (cmd_in[6:0] == 7'(k)) rdata = regs_q[k];
         end
      end
   end

   // Frame FSM state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StDisarmed;
         bitcnt_q <= '0;
         shin_q   <= '0;
         shout_q  <= '0;
         wdata_q  <= '0;
         cmd_q    <= '0;
         commit_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         shin_q   <= shin_d;
         shout_q  <= shout_d;
         wdata_q  <= wdata_d;
         cmd_q    <= cmd_d;
         commit_q <= commit_d;
      end
   end

   // Frame FSM next state: bit counting, shifting, command latch and commit request
   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      shin_d   = shin_q;
      shout_d  = shout_q;
      wdata_d  = wdata_q;
      cmd_d    = cmd_q;
      commit_d = 1'b0;
      err_set  = 1'b0;
      unique case (state_q)
         StDisarmed: begin
            if (ssel_high) state_d = StIdle;
         end
         StIdle: begin
            if (ssel_fall) begin
               state_d  = StFrame;
               bitcnt_d = '0;
               shout_d  = '0;
               shout_d[DATA_W-1 -: 8] = {7'b1010000, frame_err_q};
            end
         end
         StFrame: begin
            if (ssel_rise) begin
               state_d = StIdle;
               // Over-long frames are flagged too, although a write in them has committed
               if (bitcnt_q != '0 && bitcnt_q != BitLast) err_set = 1'b1;
            end else if (sck_rise) begin
               shin_d = {shin_q[DATA_W-2:0], mosi_s};
               if (bitcnt_q != BitSat) bitcnt_d = bitcnt_q + 1'b1;
               if (bitcnt_q == BitCmdM1) begin
                  cmd_d   = cmd_in;
                  shout_d = rdata;
               end
               // Only the transition into exactly FrameLen commits, so later edges cannot rewrite
               if (bitcnt_q == BitLastM1 && cmd_q[7]) begin
                  commit_d = 1'b1;
                  wdata_d  = shin_d;
               end
            end else if (sck_fall) begin
               // The falling edge at bitcnt=8 holds the freshly loaded read-data MSB
               if ((bitcnt_q != '0 && bitcnt_q < BitCmd) || bitcnt_q > BitCmd) begin
                  shout_d = {shout_q[DATA_W-2:0], 1'b0};
               end
            end
         end
         default: state_d = StDisarmed;
      endcase
   end

   // Register bank, counter and sticky error state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_q      <= {NREG{REG_INIT}};
         count_q     <= '0;
         frame_err_q <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
      end else begin
         regs_q      <= regs_d;
         count_q     <= count_d;
         frame_err_q <= frame_err_d;
         wr_strobe_q <= wr_strobe_d;
         wr_addr_q   <= wr_addr_d;
      end
   end

   // Write decode: committed write lands one clk after the last data bit
   always_comb begin
      regs_d      = regs_q;
      count_d     = count_q + 1'b1;
      frame_err_d = frame_err_q;
      wr_strobe_d = 1'b0;
      wr_addr_d   = wr_addr_q;
      if (commit_q) begin
         if (cmd_q[6:0] == AddrCount) begin
            count_d     = wdata_q;
            wr_strobe_d = 1'b1;
            wr_addr_d   = cmd_q[6:0];
         end else if (cmd_q[6:0] == AddrErrClr) begin
            frame_err_d = 1'b0;
         end else begin
            for (int unsigned k = 0; k < NREG; k++) begin
               if (cmd_q[6:0] == 7'(k)) begin
                  regs_d[k]   = wdata_q;
                  wr_strobe_d = 1'b1;
                  wr_addr_d   = cmd_q[6:0];
               end
            end
         end
      end
      if (err_set) frame_err_d = 1'b1;
   end

   assign miso      = shout_q[DATA_W-1];
   assign regs_out  = regs_q;
   assign wr_strobe = wr_strobe_q;
   assign wr_addr   = wr_addr_q;
   assign count     = count_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_regbank_slave.sv
// Self-checking bench for spi_regbank_slave: SPI frames driven bit by bit, results compared
// against a register-level model of the bank, the error flag and the counter.
`timescale 1ns / 1ps

module tb_spi_regbank_slave;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned NREG   = 4;
   localparam int          HALF   = 8;

   logic                   clk   = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   sck   = 1'b0;
   logic                   ssel  = 1'b1;
   logic                   mosi  = 1'b0;
   logic                   miso;
   logic [NREG*DATA_W-1:0] regs_out;
   logic                   wr_strobe;
   logic [6:0]             wr_addr;
   logic [DATA_W-1:0]      count;
   logic                   frame_err;

   spi_regbank_slave #(
      .DATA_W  (DATA_W),
      .NREG    (NREG),
      .REG_INIT('0)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sck      (sck),
      .ssel     (ssel),
      .mosi     (mosi),
      .miso     (miso),
      .regs_out (regs_out),
      .wr_strobe(wr_strobe),
      .wr_addr  (wr_addr),
      .count    (count),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model
   logic [31:0] model_regs[NREG];
   logic        model_err;

   // Strobe monitor: pulse count, addresses, and the counter around each strobe
   int          strobe_cnt = 0;
   logic [6:0]  strobe_addrs[$];
   logic [31:0] post_vals[4];
   int          post_n = 0;

   always @(negedge clk) begin
      if (wr_strobe) begin
         strobe_cnt++;
         strobe_addrs.push_back(wr_addr);
         post_vals[0] = count;
         post_n = 1;
      end else if (post_n > 0 && post_n < 4) begin
         post_vals[post_n] = count;
         post_n++;
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   // One SPI mode-0 frame of nbits clocks; rst_at >= 0 pulses rst_n low before that bit
   task automatic spi_frame(input logic [7:0] cmd, input logic [31:0] data, input int nbits,
                            input int rst_at, input int gap, output logic [7:0] status,
                            output logic [31:0] rdata, output logic [31:0] c0);
      logic [39:0] tx, rx;
      tx = {cmd, data};
      rx = '0;
      c0 = '0;
      @(negedge clk);
      ssel = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         if (i == rst_at) begin
            rst_n = 1'b0;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            repeat (2) @(negedge clk);
         end
         mosi = (i < 40) ? tx[39-i] : 1'b0;
         repeat (HALF) @(negedge clk);
         if (i < 40) rx[39-i] = miso;
         if (i == 7) c0 = count;
         sck = 1'b1;
         repeat (HALF) @(negedge clk);
         sck = 1'b0;
      end
      repeat (HALF) @(negedge clk);
      ssel = 1'b1;
      repeat (gap) @(negedge clk);
      status = rx[39:32];
      rdata  = rx[31:0];
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (regs_out !== '0) begin
         errors++; $display("FAIL reset_regs: got %h expected 0", regs_out);
      end
      checks++;
      if ({miso, wr_strobe, wr_addr, frame_err} !== '0) begin
         errors++; $display("FAIL reset_ctrl: got miso=%b strobe=%b addr=%h err=%b expected 0",
                            miso, wr_strobe, wr_addr, frame_err);
      end
      checks++;
      if (count !== '0) begin
         errors++; $display("FAIL reset_count: got %h expected 0", count);
      end
      rst_n = 1'b1;
      for (int k = 0; k < NREG; k++) model_regs[k] = '0;
      model_err = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_write_read();
      logic [7:0] st; logic [31:0] rd, c0; int s0;
      s0 = strobe_cnt;
      spi_frame(8'h81, 32'h12345678, 40, -1, 6, st, rd, c0);
      model_regs[1] = 32'h12345678;
      for (int k = 0; k < NREG; k++) begin
         checks++;
         if (regs_out[k*32 +: 32] !== model_regs[k]) begin
            errors++; $display("FAIL wr_reg%0d: got %h expected %h", k, regs_out[k*32 +: 32],
                               model_regs[k]);
         end
      end
      checks++;
      if (strobe_cnt - s0 != 1 || wr_addr !== 7'd1) begin
         errors++; $display("FAIL wr_strobe: got %0d strobes addr %h expected 1 strobe addr 01",
                            strobe_cnt - s0, wr_addr);
      end
      spi_frame(8'h01, 32'h0, 40, -1, 6, st, rd, c0);
      checks++;
      if (st !== 8'hA0) begin
         errors++; $display("FAIL rd_status: got %h expected a0", st);
      end
      checks++;
      if (rd !== 32'h12345678) begin
         errors++; $display("FAIL rd_data: got %h expected 12345678", rd);
      end
   endtask

   task automatic test_count();
      logic [7:0] st; logic [31:0] rd, c0, diff; int s0;
      s0 = strobe_cnt;
      spi_frame(8'hFF, 32'hFFFFFFFE, 40, -1, 6, st, rd, c0);
      checks++;
      if (strobe_cnt - s0 != 1 || post_n != 4) begin
         errors++; $display("FAIL cnt_strobe: got %0d strobes post %0d expected 1 strobe post 4",
                            strobe_cnt - s0, post_n);
      end
      checks++;
      if (post_vals[0] !== 32'hFFFFFFFE || post_vals[1] !== 32'hFFFFFFFF ||
          post_vals[2] !== 32'h0 || post_vals[3] !== 32'h1) begin
         errors++; $display("FAIL cnt_wrap: got %h %h %h %h expected fffffffe ffffffff 0 1",
                            post_vals[0], post_vals[1], post_vals[2], post_vals[3]);
      end
      repeat (3) @(negedge clk);
      spi_frame(8'h7F, 32'h0, 40, -1, 6, st, rd, c0);
      diff = rd - c0;
      checks++;
      if (diff < 1 || diff > 4) begin
         errors++; $display("FAIL cnt_snap: got %h expected %h+1..4", rd, c0);
      end
   endtask

   task automatic test_abort();
      logic [7:0] st; logic [31:0] rd, c0; int s0;
      s0 = strobe_cnt;
      spi_frame(8'h80, $urandom(), 20, -1, 6, st, rd, c0);
      model_err = 1'b1;
      checks++;
      if (regs_out[31:0] !== model_regs[0] || strobe_cnt != s0) begin
         errors++; $display("FAIL abort_nowr: got reg0 %h strobes %0d expected %h 0",
                            regs_out[31:0], strobe_cnt - s0, model_regs[0]);
      end
      checks++;
      if (frame_err !== 1'b1) begin
         errors++; $display("FAIL abort_err: got %b expected 1", frame_err);
      end
      spi_frame(8'h00, 32'h0, 40, -1, 6, st, rd, c0);
      checks++;
      if (st !== 8'hA1 || rd !== model_regs[0]) begin
         errors++; $display("FAIL abort_status: got %h/%h expected a1/%h", st, rd, model_regs[0]);
      end
      spi_frame(8'hFE, $urandom(), 40, -1, 6, st, rd, c0);
      model_err = 1'b0;
      checks++;
      if (frame_err !== 1'b0 || strobe_cnt != s0) begin
         errors++; $display("FAIL err_clr: got err %b strobes %0d expected 0 0", frame_err,
                            strobe_cnt - s0);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] st; logic [31:0] rd, c0, d; int s0;
      d = $urandom();
      spi_frame(8'h82, d, 40, -1, 6, st, rd, c0);
      model_regs[2] = d;
      s0 = strobe_cnt;
      spi_frame(8'h82, $urandom(), 40, 30, 6, st, rd, c0);
      for (int k = 0; k < NREG; k++) model_regs[k] = '0;
      model_err = 1'b0;
      checks++;
      if (regs_out !== '0 || strobe_cnt != s0 || wr_addr !== 7'd0) begin
         errors++; $display("FAIL rstmid_nowr: got regs %h strobes %0d addr %h expected 0 0 0",
                            regs_out, strobe_cnt - s0, wr_addr);
      end
      checks++;
      if (frame_err !== 1'b0) begin
         errors++; $display("FAIL rstmid_err: got %b expected 0", frame_err);
      end
      d = $urandom();
      spi_frame(8'h83, d, 40, -1, 6, st, rd, c0);
      model_regs[3] = d;
      checks++;
      if (regs_out[127:96] !== model_regs[3] || strobe_cnt - s0 != 1 || st !== 8'hA0) begin
         errors++; $display("FAIL rstmid_next: got %h strobes %0d status %h expected %h 1 a0",
                            regs_out[127:96], strobe_cnt - s0, st, model_regs[3]);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] st; logic [31:0] rd, c0, d; int s0; logic [6:0] addrs[5];
      addrs = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h40};
      s0 = strobe_cnt;
      strobe_addrs.delete();
      foreach (addrs[j]) begin
         d = $urandom();
         spi_frame({1'b1, addrs[j]}, d, 40, -1, 4, st, rd, c0);
         if (addrs[j] < 7'(NREG)) model_regs[addrs[j]] = d;
      end
      repeat (6) @(negedge clk);
      checks++;
      if (strobe_cnt - s0 != 4) begin
         errors++; $display("FAIL b2b_strobes: got %0d expected 4", strobe_cnt - s0);
      end
      for (int j = 0; j < 4; j++) begin
         checks++;
         if (strobe_addrs.size() <= j || strobe_addrs[j] !== 7'(j)) begin
            errors++; $display("FAIL b2b_addr%0d: got %h expected %h", j,
                               (strobe_addrs.size() > j) ? strobe_addrs[j] : 7'h7x, 7'(j));
         end
      end
      for (int k = 0; k < NREG; k++) begin
         checks++;
         if (regs_out[k*32 +: 32] !== model_regs[k]) begin
            errors++; $display("FAIL b2b_reg%0d: got %h expected %h", k, regs_out[k*32 +: 32],
                               model_regs[k]);
         end
      end
      checks++;
      if (frame_err !== 1'b0) begin
         errors++; $display("FAIL b2b_err: got %b expected 0", frame_err);
      end
   endtask

   task automatic test_frame_len();
      logic [7:0] st; logic [31:0] rd, c0, d; int s0;
      s0 = strobe_cnt;
      spi_frame(8'h81, 32'h0, 0, -1, 6, st, rd, c0);
      checks++;
      if (frame_err !== 1'b0 || strobe_cnt != s0) begin
         errors++; $display("FAIL empty_frame: got err %b strobes %0d expected 0 0", frame_err,
                            strobe_cnt - s0);
      end
      d = $urandom();
      spi_frame(8'h83, d, 41, -1, 6, st, rd, c0);
      model_regs[3] = d;
      checks++;
      if (regs_out[127:96] !== d || strobe_cnt - s0 != 1 || frame_err !== 1'b1) begin
         errors++; $display("FAIL long_frame: got %h strobes %0d err %b expected %h 1 1",
                            regs_out[127:96], strobe_cnt - s0, frame_err, d);
      end
      spi_frame(8'hFE, 32'h0, 40, -1, 6, st, rd, c0);
      checks++;
      if (frame_err !== 1'b0 || st !== 8'hA1) begin
         errors++; $display("FAIL long_clr: got err %b status %h expected 0 a1", frame_err, st);
      end
   endtask

   task automatic test_random();
      logic [7:0] st, exp_st; logic [31:0] rd, c0, d, exp_rd; logic [6:0] a; logic w; int s0;
      for (int n = 0; n < 20; n++) begin
         case ($urandom_range(0, 5))
            4:       a = 7'h7E;
            5:       a = 7'($urandom_range(NREG, 7'h7D));
            default: a = 7'($urandom_range(0, NREG - 1));
         endcase
         w = 1'($urandom_range(0, 1));
         d = $urandom();
         exp_st = {7'b1010000, model_err};
         if (a < 7'(NREG)) exp_rd = model_regs[a];
         else if (a == 7'h7E) exp_rd = {31'b0, model_err};
         else exp_rd = '0;
         s0 = strobe_cnt;
         spi_frame({w, a}, d, 40, -1, 6, st, rd, c0);
         checks++;
         if (st !== exp_st || rd !== exp_rd) begin
            errors++; $display("FAIL rand%0d_read a=%h: got %h/%h expected %h/%h", n, a, st, rd,
                               exp_st, exp_rd);
         end
         if (w && a < 7'(NREG)) model_regs[a] = d;
         if (w && a == 7'h7E) model_err = 1'b0;
         checks++;
         if (strobe_cnt - s0 != ((w && a < 7'(NREG)) ? 1 : 0) ||
             regs_out !== {model_regs[3], model_regs[2], model_regs[1], model_regs[0]}) begin
            errors++; $display("FAIL rand%0d_write a=%h w=%b: got strobes %0d regs %h", n, a, w,
                               strobe_cnt - s0, regs_out);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_count();
      test_abort();
      test_reset_mid_frame();
      test_back_to_back();
      test_frame_len();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
